alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream driver for the alu block: buffers operand/opcode commands in a small FIFO and issues them to the ALU one at a time.
- Holds start for the full operation, captures the result when done rises, and returns it on a valid/ready response port.
- Rejects undefined opcodes without issuing them, and guards every issue with a timeout.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TIMEOUT, 15, max cycles start is held waiting for alu_done before an error response is returned

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command (= not full)
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_opcode  in  4  ALU opcode
- alu_a  out  8  to alu A
- alu_b  out  8  to alu B
- alu_opcode  out  4  to alu opcode
- alu_start  out  1  to alu start
- alu_done  in  1  from alu done
- alu_result  in  16  from alu result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  16  captured result (0 on error)
- rsp_opcode  out  4  opcode of the command that produced the response
- rsp_err  out  1  1 = undefined opcode or timeout
- busy  out  1  FSM not in IDLE, or FIFO not empty
- fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, any time, including mid-operation): FIFO empty, FSM IDLE, alu_start=0, alu_a/alu_b/alu_opcode=0, rsp_valid=0, rsp_result=0, rsp_opcode=0, rsp_err=0, timeout counter=0, fifo_count=0, cmd_ready=1.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - Pop when the FSM leaves IDLE.
  - cmd_ready = (fifo_count != DEPTH). No bypass: a push while full is blocked even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Legal opcodes: 0001-0011 (arith), 0100 (mult), 0111-1000 (shift), 1001-1100 (special). All others are undefined.
- FSM IDLE:
  - If FIFO not empty and rsp slot free (rsp_valid=0), pop the head and register it onto alu_a/b/opcode.
  - Legal opcode -> ISSUE, with alu_start=1 from the next cycle.
  - Undefined opcode -> RESP directly with rsp_err=1, rsp_result=0; alu_start never asserted.
- FSM ISSUE:
  - alu_start held 1, alu_a/b/opcode held stable. Required because the mult and special paths clear their pipelines if start drops.
  - Timeout counter increments each cycle.
  - On alu_done=1: capture alu_result into rsp_result, rsp_err=0, alu_start=0 next cycle -> GAP.
  - If the counter reaches TIMEOUT with no done: alu_start=0, rsp_err=1, rsp_result=0 -> GAP.
  - Expected latency from first start cycle to done: arith/shift 1 cycle, mult/special 4 cycles.
- FSM GAP: one cycle with alu_start=0 so the alu pipelines and done flops clear -> RESP.
- FSM RESP:
  - rsp_valid=1; rsp_result, rsp_opcode and rsp_err stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0 -> IDLE.
  - Back-to-back commands: minimum spacing is 1 idle cycle between a response handshake and the next issue.
- alu_done while not in ISSUE: ignored, no state change.
- Counter width: $clog2(TIMEOUT+1) bits, cleared on entering ISSUE.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD=0001, OP_AND=0010, OP_SUB=0011, OP_MUL=0100, OP_SHL=0111, OP_SHR=1000, OP_SP1..OP_SP4=1001..1100
  - function is_legal_op(opcode)
  - seq_state_t enum {IDLE, ISSUE, GAP, RESP}
- Sub-module alu_cmd_fifo: parameterised DEPTH, 20-bit entries {a,b,opcode}, with full/empty/count outputs.

Test Plan:
- Reset, then push A=8'h05 B=8'h03 op=0001, rsp_ready=1 -> alu_start high 1 cycle; rsp_valid with rsp_result=16'h0008, rsp_opcode=0001, rsp_err=0.
- Push op=0100 A=8'h0C B=8'h0A -> alu_start held continuously until alu_done; rsp_result=16'h0078, rsp_err=0.
- Push op=1110 -> alu_start never asserted; rsp_err=1, rsp_result=0 within 3 cycles of the push.
- Hold rsp_ready=0 and push DEPTH+2 commands -> cmd_ready=0 once fifo_count=DEPTH; no command lost; responses return in order when rsp_ready=1.
- Tie alu_done=0 with a legal op -> after TIMEOUT=15 cycles alu_start drops; rsp_err=1.
- Assert reset during ISSUE of a mult -> all outputs return to reset values immediately (asynchronously); fifo_count=0; after release, a new op=0011 A=8'h09 B=8'h04 gives rsp_result=16'h0005.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcode encodings, command
// record layout, sequencer states and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SP1 = 4'b1001;
    localparam logic [3:0] OP_SP2 = 4'b1010;
    localparam logic [3:0] OP_SP3 = 4'b1011;
    localparam logic [3:0] OP_SP4 = 4'b1100;

    // One buffered command: 20 bits {a, b, opcode}
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] opcode;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} seq_state_t;

    // Opcodes the ALU implements; anything else is answered locally with an error
    function automatic logic is_legal_op(input logic [3:0] opcode);
        case (opcode)
            OP_ADD, OP_AND, OP_SUB, OP_MUL, OP_SHL, OP_SHR,
            OP_SP1, OP_SP2, OP_SP3, OP_SP4: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small command FIFO with combinational head read so the sequencer can
// register the head onto the ALU bus in the same cycle it pops.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  cmd_t                   wr_data,
    input  logic                   pop,
    output cmd_t                   rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    // A push into a full FIFO is refused even if a pop frees a slot this cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands and issues them one at a time: start is held for the
// whole operation, the result is captured on done, and each issue is
// guarded by a timeout. Undefined opcodes are answered with an error
// without ever touching the ALU.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    input  logic [3:0]             cmd_opcode,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_opcode,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_result,
    output logic [3:0]             rsp_opcode,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state_reg;
    logic [CNT_W-1:0]  tmo_cnt_reg;
    logic [CNT_W-1:0]  tmo_cnt_next;
    cmd_t              head;
    cmd_t              wr_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign wr_cmd       = '{a: cmd_a, b: cmd_b, opcode: cmd_opcode};
    assign cmd_ready    = ~fifo_full;
    assign push         = cmd_valid & ~fifo_full;
    // Only leave IDLE when the response slot is free
    assign pop          = (state_reg == IDLE) & ~fifo_empty & ~rsp_valid;
    assign busy         = (state_reg != IDLE) | ~fifo_empty;
    assign tmo_cnt_next = tmo_cnt_reg + 1'b1;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Issue FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            tmo_cnt_reg <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            alu_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_opcode  <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        alu_a       <= head.a;
                        alu_b       <= head.b;
                        alu_opcode  <= head.opcode;
                        rsp_opcode  <= head.opcode;
                        tmo_cnt_reg <= '0;
                        if (is_legal_op(head.opcode)) begin
                            alu_start <= 1'b1;
                            state_reg <= ISSUE;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            state_reg  <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    // Start stays high with a stable bus; multi-cycle paths flush if it drops
                    tmo_cnt_reg <= tmo_cnt_next;
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                        alu_start  <= 1'b0;
                        state_reg  <= GAP;
                    end else if (tmo_cnt_next == CNT_W'(TIMEOUT)) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        alu_start  <= 1'b0;
                        state_reg  <= GAP;
                    end
                end
                GAP: begin
                    // One start-low cycle lets the ALU pipelines and done flop clear
                    rsp_valid <= 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: a behavioural ALU answers start with the expected
// latency, and responses are compared in order against a queue of expected
// results computed from the opcode rules.
module tb_alu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  op;
        logic        err;
    } rsp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [7:0]             cmd_a = 8'h00;
    logic [7:0]             cmd_b = 8'h00;
    logic [3:0]             cmd_opcode = 4'h0;
    logic [7:0]             alu_a;
    logic [7:0]             alu_b;
    logic [3:0]             alu_opcode;
    logic                   alu_start;
    logic                   alu_done;
    logic [15:0]            alu_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [15:0]            rsp_result;
    logic [3:0]             rsp_opcode;
    logic                   rsp_err;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   push_cyc = 0;
    int   hold_seen = 0;
    int   start_cnt = 0;
    int   rise_cnt = 0;
    int   stab_viol = 0;
    logic prev_start = 1'b0;
    logic [19:0] prev_bus = '0;
    logic done_en = 1'b1;
    logic rand_mode = 1'b0;
    logic ready_fix = 1'b0;
    logic rnd_bit = 1'b0;
    logic spur = 1'b0;

    rsp_t exp_q [$];
    rsp_t rsp_q [$];
    int   rsp_cyc_q [$];

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_opcode (cmd_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_opcode (rsp_opcode),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference rules ----------------
    function automatic bit tb_legal(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    endfunction

    function automatic int op_latency(input logic [3:0] op);
        return (op == 4'd4 || (op >= 4'd9 && op <= 4'd12)) ? 4 : 1;
    endfunction

    function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd1:    return {8'h00, a} + {8'h00, b};
            4'd2:    return {8'h00, a & b};
            4'd3:    return {8'h00, a} - {8'h00, b};
            4'd4:    return {8'h00, a} * {8'h00, b};
            4'd7:    return {8'h00, a} << b[2:0];
            4'd8:    return {8'h00, a >> b[2:0]};
            4'd9:    return {a, b};
            4'd10:   return {b, a};
            4'd11:   return {a ^ b, a | b};
            4'd12:   return ~{a, b};
            default: return 16'h0000;
        endcase
    endfunction

    // ---------------- behavioural ALU ----------------
    assign alu_done   = alu_start ? (done_en && hold_seen == op_latency(alu_opcode)) : spur;
    assign alu_result = alu_done ? ref_alu(alu_a, alu_b, alu_opcode) : 16'hDEAD;
    assign rsp_ready  = rand_mode ? rnd_bit : ready_fix;

    always @(negedge clk) begin
        hold_seen <= alu_start ? hold_seen + 1 : 0;
        rnd_bit   <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        spur      <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Start activity and bus stability monitor
    always @(negedge clk) begin
        if (alu_start) start_cnt <= start_cnt + 1;
        if (alu_start && !prev_start) rise_cnt <= rise_cnt + 1;
        if (alu_start && prev_start && {alu_a, alu_b, alu_opcode} != prev_bus) stab_viol <= stab_viol + 1;
        prev_start <= alu_start;
        prev_bus   <= {alu_a, alu_b, alu_opcode};
    end

    // Response handshake recorder
    always @(negedge clk) begin
        #2;
        if (rsp_valid && rsp_ready) begin
            rsp_q.push_back('{res: rsp_result, op: rsp_opcode, err: rsp_err});
            rsp_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bit   acc;
        rsp_t e;
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (!acc) begin
            $display("FAIL push_accept: op=%h never accepted, got cmd_ready=0 expected 1", op);
            n_err++;
        end else begin
            push_cyc = cyc;
            e.op  = op;
            e.err = !tb_legal(op) || !done_en;
            e.res = e.err ? 16'h0000 : ref_alu(a, b, op);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_rsp(output rsp_t r, output int rc, output bit ok);
        ok = 1'b0;
        r  = '0;
        rc = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_q.size() > 0) begin
                r  = rsp_q.pop_front();
                rc = rsp_cyc_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; ready_fix = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({cmd_ready, alu_start, rsp_valid, rsp_err, busy} !== 5'b10000) begin
            $display("FAIL reset_ctrl: got {rdy,start,vld,err,busy}=%b expected 10000",
                     {cmd_ready, alu_start, rsp_valid, rsp_err, busy});
            n_err++;
        end
        n_vec++;
        if (fifo_count !== '0) begin
            $display("FAIL reset_count: got %0d expected 0", fifo_count);
            n_err++;
        end
        n_vec++;
        if ({alu_a, alu_b, alu_opcode, rsp_result, rsp_opcode} !== 40'h0) begin
            $display("FAIL reset_data: got %h expected 0", {alu_a, alu_b, alu_opcode, rsp_result, rsp_opcode});
            n_err++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL post_reset_idle: got rdy=%b busy=%b expected 1 0", cmd_ready, busy);
            n_err++;
        end
    endtask

    task automatic test_add();
        rsp_t r; int rc; bit ok; int s0;
        ready_fix = 1'b1;
        s0 = start_cnt;
        push_cmd(8'h05, 8'h03, 4'b0001);
        wait_rsp(r, rc, ok);
        n_vec++;
        if (!ok || r.res !== 16'h0008 || r.op !== 4'b0001 || r.err !== 1'b0) begin
            $display("FAIL add_rsp: ok=%b got res=%h op=%h err=%b expected res=0008 op=1 err=0", ok, r.res, r.op, r.err);
            n_err++;
        end
        n_vec++;
        if (start_cnt - s0 != 1) begin
            $display("FAIL add_start_len: got %0d cycles expected 1", start_cnt - s0);
            n_err++;
        end
        exp_q.delete();
    endtask

    task automatic test_mult();
        rsp_t r; int rc; bit ok; int s0, r0, v0;
        s0 = start_cnt; r0 = rise_cnt; v0 = stab_viol;
        push_cmd(8'h0C, 8'h0A, 4'b0100);
        wait_rsp(r, rc, ok);
        n_vec++;
        if (!ok || r.res !== 16'h0078 || r.err !== 1'b0) begin
            $display("FAIL mult_rsp: ok=%b got res=%h err=%b expected res=0078 err=0", ok, r.res, r.err);
            n_err++;
        end
        n_vec++;
        if (start_cnt - s0 != 4 || rise_cnt - r0 != 1) begin
            $display("FAIL mult_start_hold: got %0d cycles %0d pulses expected 4 cycles 1 pulse",
                     start_cnt - s0, rise_cnt - r0);
            n_err++;
        end
        n_vec++;
        if (stab_viol != v0) begin
            $display("FAIL mult_bus_stable: got %0d changes while start held expected 0", stab_viol - v0);
            n_err++;
        end
        exp_q.delete();
    endtask

    task automatic test_illegal();
        rsp_t r; int rc; bit ok; int s0;
        s0 = start_cnt;
        push_cmd(8'h33, 8'h44, 4'b1110);
        wait_rsp(r, rc, ok);
        n_vec++;
        if (!ok || r.res !== 16'h0000 || r.op !== 4'b1110 || r.err !== 1'b1) begin
            $display("FAIL illegal_rsp: ok=%b got res=%h op=%h err=%b expected res=0000 op=e err=1", ok, r.res, r.op, r.err);
            n_err++;
        end
        n_vec++;
        if (start_cnt != s0) begin
            $display("FAIL illegal_no_start: got %0d start cycles expected 0", start_cnt - s0);
            n_err++;
        end
        n_vec++;
        if (rc - push_cyc > 3) begin
            $display("FAIL illegal_latency: got %0d cycles expected <= 3", rc - push_cyc);
            n_err++;
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [3:0] legal_ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        rsp_t r; rsp_t e; int rc; bit ok;
        logic [7:0] a6, b6;
        ready_fix = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_cmd(8'($urandom), 8'($urandom), legal_ops[$urandom_range(0, 9)]);
        end
        n_vec++;
        if (fifo_count !== (DEPTH) || cmd_ready !== 1'b0) begin
            $display("FAIL full_flag: got count=%0d rdy=%b expected %0d 0", fifo_count, cmd_ready, DEPTH);
            n_err++;
        end
        a6 = 8'($urandom); b6 = 8'($urandom);
        cmd_a = a6; cmd_b = b6; cmd_opcode = 4'd11; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (fifo_count !== (DEPTH)) begin
            $display("FAIL full_blocks_push: got count=%0d expected %0d", fifo_count, DEPTH);
            n_err++;
        end
        ready_fix = 1'b1;
        push_cmd(a6, b6, 4'd11);
        for (int i = 0; i < DEPTH + 2; i++) begin
            wait_rsp(r, rc, ok);
            e = exp_q.pop_front();
            n_vec++;
            if (!ok || r !== e) begin
                $display("FAIL bp_order[%0d]: ok=%b got res=%h op=%h err=%b expected res=%h op=%h err=%b",
                         i, ok, r.res, r.op, r.err, e.res, e.op, e.err);
                n_err++;
            end
        end
    endtask

    task automatic test_timeout();
        rsp_t r; int rc; bit ok; int s0;
        done_en = 1'b0;
        s0 = start_cnt;
        push_cmd(8'h11, 8'h22, 4'b0010);
        wait_rsp(r, rc, ok);
        n_vec++;
        if (!ok || r.res !== 16'h0000 || r.op !== 4'b0010 || r.err !== 1'b1) begin
            $display("FAIL timeout_rsp: ok=%b got res=%h op=%h err=%b expected res=0000 op=2 err=1", ok, r.res, r.op, r.err);
            n_err++;
        end
        n_vec++;
        if (start_cnt - s0 != TIMEOUT) begin
            $display("FAIL timeout_len: got %0d start cycles expected %0d", start_cnt - s0, TIMEOUT);
            n_err++;
        end
        done_en = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_issue();
        rsp_t r; int rc; bit ok;
        done_en = 1'b0;
        push_cmd(8'h07, 8'h06, 4'b0100);
        push_cmd(8'h01, 8'h01, 4'b0001);
        repeat (2) @(negedge clk);
        n_vec++;
        if (alu_start !== 1'b1 || fifo_count !== 1) begin
            $display("FAIL pre_reset_issue: got start=%b count=%0d expected 1 1", alu_start, fifo_count);
            n_err++;
        end
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({alu_start, rsp_valid, rsp_err, busy, cmd_ready} !== 5'b00001 || fifo_count !== '0) begin
            $display("FAIL async_reset_ctrl: got {start,vld,err,busy,rdy}=%b count=%0d expected 00001 0",
                     {alu_start, rsp_valid, rsp_err, busy, cmd_ready}, fifo_count);
            n_err++;
        end
        n_vec++;
        if ({alu_a, alu_b, alu_opcode, rsp_result, rsp_opcode} !== 40'h0) begin
            $display("FAIL async_reset_data: got %h expected 0", {alu_a, alu_b, alu_opcode, rsp_result, rsp_opcode});
            n_err++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_en = 1'b1;
        exp_q.delete();
        rsp_q.delete();
        rsp_cyc_q.delete();
        @(negedge clk);
        push_cmd(8'h09, 8'h04, 4'b0011);
        wait_rsp(r, rc, ok);
        n_vec++;
        if (!ok || r.res !== 16'h0005 || r.op !== 4'b0011 || r.err !== 1'b0) begin
            $display("FAIL post_reset_sub: ok=%b got res=%h op=%h err=%b expected res=0005 op=3 err=0", ok, r.res, r.op, r.err);
            n_err++;
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        localparam int NR = 24;
        rsp_t r; rsp_t e;
        int waited;
        exp_q.delete();
        rand_mode = 1'b1;
        for (int i = 0; i < NR; i++) begin
            push_cmd(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
        end
        rand_mode = 1'b0;
        ready_fix = 1'b1;
        waited = 0;
        while (rsp_q.size() < NR && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (rsp_q.size() != NR) begin
            $display("FAIL random_count: got %0d responses expected %0d", rsp_q.size(), NR);
            n_err++;
        end
        while (exp_q.size() > 0 && rsp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            void'(rsp_cyc_q.pop_front());
            n_vec++;
            if (r !== e) begin
                $display("FAIL random_rsp: got res=%h op=%h err=%b expected res=%h op=%h err=%b",
                         r.res, r.op, r.err, e.res, e.op, e.err);
                n_err++;
            end
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || fifo_count !== '0) begin
            $display("FAIL random_drain: got busy=%b count=%0d expected 0 0", busy, fifo_count);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_illegal();
        test_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
